key_event_decoder: RTL and testbench

Consumes the debounced, active-low key pulses produced by the key debouncer (press = falling edge, release = rising edge) and classifies them into single-cycle user events: short press, double click, long press and, optionally, auto-repeat while held. It sits between the debouncer and the application control logic, so downstream blocks only ever see clean one-cycle event strobes.

---
 rtl/key_event_decoder.sv | 170 +++++++++++++++++
 tb/tb_key_event_decoder.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/key_event_decoder.sv
// key_event_decoder
//   Classifies debounced key press/release pulses into one-cycle user events:
//   short press, double click, long press and (optionally) auto-repeat.
//
//   Ports:
//     clk          in   system clock
//     rst_n        in   asynchronous active-low reset
//     key_press    in   one-cycle pulse, key went pressed
//     key_release  in   one-cycle pulse, key went released
//     short_press  out  strobe, single short press confirmed
//     double_click out  strobe, two short presses within DCLICK_MS
//     long_press   out  strobe, key held for LONG_MS
//     repeat_tick  out  strobe every REPEAT_MS while held (KEY_REPEAT_EN only)
//     busy         out  high whenever the FSM is not IDLE
//
//   Build option: define KEY_REPEAT_EN to enable auto-repeat in HOLD;
//   otherwise repeat_tick is constant 0.
//
//   state  | meaning
//   IDLE   | waiting for a first press
//   PRESS1 | first press down, timing toward long press
//   WAIT2  | released, timing the double-click window
//   PRESS2 | second press down, timing toward long press
//   HOLD   | long press issued, waiting for release
module key_event_decoder #(
  parameter int FREQ      = 50,
  parameter int LONG_MS   = 1000,
  parameter int DCLICK_MS = 300,
  parameter int REPEAT_MS = 200
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_press,
  input  logic key_release,
  output logic short_press,
  output logic double_click,
  output logic long_press,
  output logic repeat_tick,
  output logic busy
);

  localparam int PRESC_MAX = FREQ * 1000 - 1;
  localparam int PW        = $clog2(FREQ * 1000);
  localparam logic [16:0] LONG_LIM   = 17'(LONG_MS);
  localparam logic [16:0] DCLICK_LIM = 17'(DCLICK_MS);

  if (FREQ < 1 || LONG_MS < 1 || LONG_MS > 65535 || DCLICK_MS < 1 ||
      DCLICK_MS > 65535 || REPEAT_MS < 1 || REPEAT_MS > 65535) begin : g_bad_param
    $error("key_event_decoder: parameter out of range");
  end

  typedef enum logic [2:0] {IDLE, PRESS1, WAIT2, PRESS2, HOLD} state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [15:0]   ms_cnt_q, ms_cnt_d;
  logic          short_q, short_d;
  logic          double_q, double_d;
  logic          long_q, long_d;
  logic          repeat_q, repeat_d;
  logic          busy_q, busy_d;

  logic ms_tick, hit_long, hit_dclick, press_v, release_v, restart;

  // Thresholds fire on the edge where ms_cnt would step onto the limit, so the
  // strobe lands exactly LIMIT*FREQ*1000 cycles after the entering edge.
  assign ms_tick    = (presc_q == PW'(PRESC_MAX));
  assign hit_long   = ms_tick && (({1'b0, ms_cnt_q} + 17'd1) == LONG_LIM);
  assign hit_dclick = ms_tick && (({1'b0, ms_cnt_q} + 17'd1) == DCLICK_LIM);

  // Simultaneous press and release is a glitch: neither is seen.
  assign press_v   = key_press & ~key_release;
  assign release_v = key_release & ~key_press;

`ifdef KEY_REPEAT_EN
  localparam logic [16:0] REPEAT_LIM = 17'(REPEAT_MS);
  logic hit_repeat;
  assign hit_repeat = ms_tick && (({1'b0, ms_cnt_q} + 17'd1) == REPEAT_LIM);
`endif

  always_comb begin
    state_d  = state_q;
    presc_d  = ms_tick ? '0 : presc_q + 1'b1;
    ms_cnt_d = (ms_tick && ms_cnt_q != 16'hFFFF) ? ms_cnt_q + 16'd1 : ms_cnt_q;
    short_d  = 1'b0;
    double_d = 1'b0;
    long_d   = 1'b0;
    repeat_d = 1'b0;
    restart  = 1'b0;

    // Timeouts are tested before key inputs so they win a same-cycle tie.
    unique case (state_q)
      IDLE: if (press_v) state_d = PRESS1;
      PRESS1: begin
        if (hit_long) begin
          long_d  = 1'b1;
          state_d = HOLD;
        end else if (release_v) begin
          state_d = WAIT2;
        end
      end
      WAIT2: begin
        if (hit_dclick) begin
          short_d = 1'b1;
          state_d = IDLE;
        end else if (press_v) begin
          state_d = PRESS2;
        end
      end
      PRESS2: begin
        if (hit_long) begin
          long_d  = 1'b1;
          state_d = HOLD;
        end else if (release_v) begin
          double_d = 1'b1;
          state_d  = IDLE;
        end
      end
      HOLD: begin
        // Release takes priority here so the key state never desynchronises.
        if (release_v) begin
          state_d = IDLE;
        end
`ifdef KEY_REPEAT_EN
        else if (hit_repeat) begin
          repeat_d = 1'b1;
          restart  = 1'b1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase

    if (restart || state_d != state_q) begin
      presc_d  = '0;
      ms_cnt_d = '0;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      presc_q  <= '0;
      ms_cnt_q <= '0;
      short_q  <= 1'b0;
      double_q <= 1'b0;
      long_q   <= 1'b0;
      repeat_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      presc_q  <= presc_d;
      ms_cnt_q <= ms_cnt_d;
      short_q  <= short_d;
      double_q <= double_d;
      long_q   <= long_d;
      repeat_q <= repeat_d;
      busy_q   <= busy_d;
    end
  end

  assign short_press  = short_q;
  assign double_click = double_q;
  assign long_press   = long_q;
  assign repeat_tick  = repeat_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_key_event_decoder.sv
// Testbench for key_event_decoder: timestamp-based reference model checked
// every cycle, directed scenarios with literal timing expectations, then
// randomized press/release sequences.
module tb_key_event_decoder;

  localparam int FREQ      = 1;
  localparam int LONG_MS   = 5;
  localparam int DCLICK_MS = 3;
  localparam int REPEAT_MS = 2;
  localparam longint P     = FREQ * 1000;

`ifdef KEY_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic key_press = 1'b0;
  logic key_release = 1'b0;
  logic short_press, double_click, long_press, repeat_tick, busy;

  int checks = 0;
  int errors = 0;

  key_event_decoder #(
    .FREQ(FREQ), .LONG_MS(LONG_MS), .DCLICK_MS(DCLICK_MS), .REPEAT_MS(REPEAT_MS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .key_press(key_press), .key_release(key_release),
    .short_press(short_press), .double_click(double_click), .long_press(long_press),
    .repeat_tick(repeat_tick), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic void chk(string nm, longint act, longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endfunction

  // Reference model: phase plus the edge at which the current timed interval
  // began; a threshold is reached when the edge count since then equals
  // LIMIT*P.  phase: 0 idle, 1 first press down, 2 gap, 3 second press down,
  // 4 held after long press.
  int     ph;
  longint n, t0, t_in_press, t_in_rel;
  bit     e_s, e_d, e_l, e_r, e_b;

  always @(posedge clk or negedge rst_n) begin : model
    bit p, r;
    longint el;
    int nph;
    if (!rst_n) begin
      ph = 0; n = 0; t0 = 0;
      e_s = 0; e_d = 0; e_l = 0; e_r = 0; e_b = 0;
    end else begin
      n++;
      p = key_press && !key_release;
      r = key_release && !key_press;
      if (p) t_in_press = n;
      if (r) t_in_rel = n;
      el = n - t0;
      nph = ph;
      e_s = 0; e_d = 0; e_l = 0; e_r = 0;
      case (ph)
        0: if (p) nph = 1;
        1: if (el == LONG_MS * P) begin e_l = 1; nph = 4; end
           else if (r) nph = 2;
        2: if (el == DCLICK_MS * P) begin e_s = 1; nph = 0; end
           else if (p) nph = 3;
        3: if (el == LONG_MS * P) begin e_l = 1; nph = 4; end
           else if (r) begin e_d = 1; nph = 0; end
        default: if (r) nph = 0;
                 else if (REP_EN && el == REPEAT_MS * P) begin e_r = 1; t0 = n; end
      endcase
      if (nph != ph) begin
        ph = nph;
        t0 = n;
      end
      e_b = (ph != 0);
    end
  end

  // Per-cycle compare against the model, plus strobe counts/timestamps.
  int     cnt_s = 0, cnt_d = 0, cnt_l = 0, cnt_r = 0;
  longint dut_t_s, dut_t_d, dut_t_l;
  longint dut_rep_q[$];

  always @(negedge clk) begin
    if (rst_n) begin
      chk("short_press", short_press, e_s);
      chk("double_click", double_click, e_d);
      chk("long_press", long_press, e_l);
      chk("repeat_tick", repeat_tick, e_r);
      chk("busy", busy, e_b);
      if (short_press)  begin cnt_s++; dut_t_s = n; end
      if (double_click) begin cnt_d++; dut_t_d = n; end
      if (long_press)   begin cnt_l++; dut_t_l = n; end
      if (repeat_tick)  begin cnt_r++; dut_rep_q.push_back(n); end
    end
  end

  task automatic cyc(input bit p, input bit r);
    @(negedge clk);
    key_press   = p;
    key_release = r;
  endtask

  task automatic idle(input int k);
    repeat (k) cyc(1'b0, 1'b0);
  endtask

  int b_s, b_d, b_l, b_r;
  task automatic snap();
    b_s = cnt_s; b_d = cnt_d; b_l = cnt_l; b_r = cnt_r;
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_short", short_press, 0);
    chk("reset_double", double_click, 0);
    chk("reset_long", long_press, 0);
    chk("reset_repeat", repeat_tick, 0);
    chk("reset_busy", busy, 0);
    rst_n = 1'b1;

    // Short press: release after 2000 cycles, short_press 3000 after release.
    snap();
    cyc(1, 0); idle(1999); cyc(0, 1); idle(3100);
    chk("short_count", cnt_s - b_s, 1);
    chk("short_delay", dut_t_s - t_in_rel, 3000);
    chk("short_no_double", cnt_d - b_d, 0);
    chk("short_no_long", cnt_l - b_l, 0);
    chk("short_busy_after", busy, 0);

    // Double click.
    snap();
    cyc(1, 0); idle(999); cyc(0, 1); idle(1499);
    cyc(1, 0); idle(999); cyc(0, 1); idle(3);
    chk("dbl_count", cnt_d - b_d, 1);
    chk("dbl_delay", dut_t_d - t_in_rel, 0);
    idle(3100);
    chk("dbl_no_short", cnt_s - b_s, 0);
    chk("dbl_busy_after", busy, 0);

    // Long hold of 12000 cycles.
    snap();
    dut_rep_q.delete();
    cyc(1, 0); idle(11999); cyc(0, 1); idle(2500);
    chk("hold_long_count", cnt_l - b_l, 1);
    chk("hold_long_delay", dut_t_l - t_in_press, 5000);
    chk("hold_repeat_count", cnt_r - b_r, REP_EN ? 3 : 0);
    foreach (dut_rep_q[i])
      chk("hold_repeat_time", dut_rep_q[i] - t_in_press, 7000 + 2000 * i);
    chk("hold_no_short", cnt_s - b_s, 0);
    chk("hold_busy_after", busy, 0);

    // Glitch (press+release together) in IDLE and in PRESS1.
    snap();
    cyc(1, 1); idle(2);
    chk("glitch_idle_busy", busy, 0);
    cyc(1, 0); idle(999); cyc(1, 1); idle(3999); idle(5);
    chk("glitch_long_count", cnt_l - b_l, 1);
    chk("glitch_long_delay", dut_t_l - t_in_press, 5000);
    chk("glitch_no_short", cnt_s - b_s, 0);
    cyc(0, 1); idle(5);
    chk("glitch_busy_after", busy, 0);

    // Release on the exact long-press edge: timeout wins, stay held.
    snap();
    cyc(1, 0); idle(4999); cyc(0, 1); idle(3);
    chk("tie_long_count", cnt_l - b_l, 1);
    chk("tie_long_busy", busy, 1);
    idle(3100);
    chk("tie_long_no_short", cnt_s - b_s, 0);
    cyc(0, 1); idle(3);
    chk("tie_long_exit_busy", busy, 0);

    // Second press exactly at the double-click timeout: short wins.
    snap();
    cyc(1, 0); idle(499); cyc(0, 1); idle(2999); cyc(1, 0); idle(3);
    chk("tie_dclick_short", cnt_s - b_s, 1);
    chk("tie_dclick_busy", busy, 0);
    // One cycle earlier: double click.
    snap();
    cyc(1, 0); idle(499); cyc(0, 1); idle(2998); cyc(1, 0); idle(499); cyc(0, 1); idle(3);
    chk("edge_dclick_double", cnt_d - b_d, 1);
    chk("edge_dclick_no_short", cnt_s - b_s, 0);

    // Reset at cycle 4000 of a hold.
    snap();
    cyc(1, 0); idle(3999);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_long", long_press, 0);
    chk("rst_mid_short", short_press, 0);
    idle(3);
    rst_n = 1'b1;
    idle(3000); cyc(0, 1); idle(3);
    chk("rst_no_long", cnt_l - b_l, 0);
    chk("rst_busy_after", busy, 0);

    // Randomized sequences, waits biased toward the thresholds.
    for (int i = 0; i < 16; i++) begin
      int k, w, sel;
      k = $urandom_range(0, 9);
      if (k <= 3)      cyc(1, 0);
      else if (k <= 7) cyc(0, 1);
      else             cyc(1, 1);
      sel = $urandom_range(0, 3);
      case (sel)
        0: w = $urandom_range(0, 50);
        1: w = $urandom_range(1990, 2010);
        2: w = $urandom_range(2990, 3010);
        default: w = $urandom_range(0, 1200);
      endcase
      idle(w);
    end
    cyc(0, 1); idle(10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
